// File: rtl/hub75_capture.sv
// HUB75 bus capture: samples the panel bus, rebuilds each shifted line and drains it as a {row, col} pixel stream.
// Optional OE on-time measurement is enabled by defining HUB75_CAPTURE_OE_MEASURE_EN.
module hub75_capture #(
   parameter int COLS     = 64,
   parameter int COL_BITS = 6,
   parameter int ROW_BITS = 5,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          h75_rgb,
   input  logic [ROW_BITS-1:0] h75_addr,
   input  logic                h75_oe,
   input  logic                h75_clk,
   input  logic                h75_lat,
   output logic                px_valid,
   input  logic                px_ready,
   output logic [ROW_BITS-1:0] px_row,
   output logic [COL_BITS-1:0] px_col,
   output logic [5:0]          px_data,
   output logic                line_done,
   output logic [COL_BITS:0]   shift_count,
   output logic                overrun,
   output logic                short_line,
   output logic [CNT_BITS-1:0] oe_cycles
);

   localparam int CW = COL_BITS + 1;
   localparam logic [CW-1:0]       CNT_SAT  = CW'(COLS + 1);
   localparam logic [CW-1:0]       CNT_FULL = CW'(COLS);
   localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   logic [5:0]          rgb_s1_r, rgb_s2_r;
   logic [ROW_BITS-1:0] addr_s1_r, addr_s2_r;
   logic                oe_s1_r, oe_s2_r;
   logic [2:0]          bclk_r, blat_r;
   logic                clk_rise_s, lat_rise_s, latch_accept_s;

   logic [5:0]    sr_r      [COLS];
   logic [5:0]    sr_next_s [COLS];
   logic [5:0]    hold_r    [COLS];
   logic [CW-1:0] bit_cnt_r, bit_cnt_next_s;
   state_t        state_r;

   assign clk_rise_s     = bclk_r[1] & ~bclk_r[2];
   assign lat_rise_s     = blat_r[1] & ~blat_r[2];
   assign latch_accept_s = lat_rise_s & (state_r != ST_DRAIN);

   // Next shift-register contents and bit count; a latch in the same cycle sees these values.
   always_comb begin
      for (int i = 0; i < COLS; i++) begin
         sr_next_s[i] = sr_r[i];
      end
      bit_cnt_next_s = bit_cnt_r;
      if (clk_rise_s) begin
         sr_next_s[0] = rgb_s2_r;
         for (int i = 1; i < COLS; i++) begin
            sr_next_s[i] = sr_r[i-1];
         end
         if (bit_cnt_r != CNT_SAT) begin
            bit_cnt_next_s = bit_cnt_r + CW'(1);
         end else begin
            bit_cnt_next_s = bit_cnt_r;
         end
      end else begin
         bit_cnt_next_s = bit_cnt_r;
      end
   end

   // Bus synchronisers, line shift register and bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_s1_r  <= 6'd0;
         rgb_s2_r  <= 6'd0;
         addr_s1_r <= '0;
         addr_s2_r <= '0;
         oe_s1_r   <= 1'b1;
         oe_s2_r   <= 1'b1;
         bclk_r    <= 3'd0;
         blat_r    <= 3'd0;
         bit_cnt_r <= '0;
         for (int i = 0; i < COLS; i++) begin
            sr_r[i] <= 6'd0;
         end
      end else begin
         rgb_s1_r  <= h75_rgb;
         rgb_s2_r  <= rgb_s1_r;
         addr_s1_r <= h75_addr;
         addr_s2_r <= addr_s1_r;
         oe_s1_r   <= h75_oe;
         oe_s2_r   <= oe_s1_r;
         bclk_r    <= {bclk_r[1:0], h75_clk};
         blat_r    <= {blat_r[1:0], h75_lat};
         sr_r      <= sr_next_s;
         // Every latch restarts the count, whether or not the drain accepts it.
         bit_cnt_r <= lat_rise_s ? '0 : bit_cnt_next_s;
      end
   end

   // Drain FSM: latch capture, pixel stream, status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         px_valid    <= 1'b0;
         px_row      <= '0;
         px_col      <= '0;
         px_data     <= 6'd0;
         line_done   <= 1'b0;
         shift_count <= '0;
         overrun     <= 1'b0;
         short_line  <= 1'b0;
         for (int i = 0; i < COLS; i++) begin
            hold_r[i] <= 6'd0;
         end
      end else begin
         line_done <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (latch_accept_s) begin
                  hold_r      <= sr_next_s;
                  px_row      <= addr_s2_r;
                  shift_count <= bit_cnt_next_s;
                  if (bit_cnt_next_s != CNT_FULL) begin
                     short_line <= 1'b1;
                  end else begin
                     short_line <= short_line;
                  end
                  px_col   <= '0;
                  px_data  <= sr_next_s[0];
                  px_valid <= 1'b1;
                  state_r  <= ST_DRAIN;
               end else begin
                  px_valid <= 1'b0;
                  state_r  <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (lat_rise_s) begin
                  overrun <= 1'b1;
               end else begin
                  overrun <= overrun;
               end
               if (px_ready) begin
                  if (px_col == LAST_COL) begin
                     px_valid  <= 1'b0;
                     line_done <= 1'b1;
                     state_r   <= ST_DONE;
                  end else begin
                     px_col  <= px_col + COL_BITS'(1);
                     px_data <= hold_r[px_col + COL_BITS'(1)];
                  end
               end else begin
                  px_col  <= px_col;
                  px_data <= px_data;
               end
            end
            default: begin
               px_valid <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef HUB75_CAPTURE_OE_MEASURE_EN
   logic [CNT_BITS-1:0] oe_cnt_r;

   // OE-low cycle counter, snapshotted and cleared by every accepted latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         oe_cnt_r  <= '0;
         oe_cycles <= '0;
      end else if (latch_accept_s) begin
         oe_cycles <= oe_cnt_r;
         oe_cnt_r  <= '0;
      end else if (!oe_s2_r && (oe_cnt_r != {CNT_BITS{1'b1}})) begin
         oe_cnt_r  <= oe_cnt_r + CNT_BITS'(1);
      end else begin
         oe_cnt_r  <= oe_cnt_r;
      end
   end
`else
   assign oe_cycles = '0;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: full/stalled/short lines, overrun, mid-drain reset, OE measure.
module tb_hub75_capture;

   logic        clk;
   logic        rst;
   logic [5:0]  h75_rgb;
   logic [4:0]  h75_addr;
   logic        h75_oe;
   logic        h75_clk;
   logic        h75_lat;
   logic        px_valid;
   logic        px_ready;
   logic [4:0]  px_row;
   logic [5:0]  px_col;
   logic [5:0]  px_data;
   logic        line_done;
   logic [6:0]  shift_count;
   logic        overrun;
   logic        short_line;
   logic [15:0] oe_cycles;

   hub75_capture dut (
      .clk(clk), .rst(rst), .h75_rgb(h75_rgb), .h75_addr(h75_addr), .h75_oe(h75_oe),
      .h75_clk(h75_clk), .h75_lat(h75_lat), .px_valid(px_valid), .px_ready(px_ready),
      .px_row(px_row), .px_col(px_col), .px_data(px_data), .line_done(line_done),
      .shift_count(shift_count), .overrun(overrun), .short_line(short_line),
      .oe_cycles(oe_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   int ready_mode = 1;     // 0: never ready, 1: always ready, 2: toggle

   logic [11:0] beats[$];
   int          ld_cnt, ld_beats, n_stall, stall_viol;
   logic [5:0]  exp_d [64];

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      px_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       px_ready = 1'b0;
            1:       px_ready = 1'b1;
            default: px_ready = ~px_ready;
         endcase
      end
   end

   // Records accepted beats, line_done pulses and stall stability.
   initial begin
      logic       stall_prev;
      logic [5:0] st_col, st_data;
      stall_prev = 1'b0;
      st_col = 6'd0;
      st_data = 6'd0;
      forever begin
         @(negedge clk);
         if (stall_prev && px_valid && (px_col != st_col || px_data != st_data)) stall_viol++;
         if (px_valid && px_ready) beats.push_back({px_col, px_data});
         if (px_valid && !px_ready) n_stall++;
         stall_prev = px_valid && !px_ready;
         st_col  = px_col;
         st_data = px_data;
         if (line_done) begin
            ld_cnt++;
            ld_beats = beats.size();
         end
      end
   end

   task automatic clear_mon();
      beats.delete();
      ld_cnt = 0;
      ld_beats = 0;
      n_stall = 0;
      stall_viol = 0;
   endtask

   task automatic bus_px(input logic [5:0] d);
      h75_rgb = d;
      h75_clk = 1'b0;
      repeat (3) @(negedge clk);
      h75_clk = 1'b1;
      repeat (3) @(negedge clk);
      h75_clk = 1'b0;
   endtask

   task automatic bus_latch(input logic [4:0] a);
      h75_addr = a;
      repeat (3) @(negedge clk);
      h75_lat = 1'b1;
      repeat (3) @(negedge clk);
      h75_lat = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 2000 && ld_cnt < 1; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check_vec({tag, "_line_done_cnt"}, ld_cnt, 1);
      check_vec({tag, "_beats_before_done"}, ld_beats, 64);
      check_vec({tag, "_valid_after"}, px_valid, 1'b0);
   endtask

   task automatic check_line(input string tag);
      check_vec({tag, "_nbeats"}, beats.size(), 64);
      for (int c = 0; c < 64 && c < beats.size(); c++) begin
         check_vec($sformatf("%s_beat%0d", tag, c), beats[c], {6'(c), exp_d[c]});
      end
   endtask

   initial begin
      logic [31:0] oe_exp;
      bit found;
      rst = 1'b1; h75_rgb = 6'd0; h75_addr = 5'd0; h75_oe = 1'b1;
      h75_clk = 1'b0; h75_lat = 1'b0;
      clear_mon();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_vec("rst_valid", px_valid, 1'b0);
      check_vec("rst_line_done", line_done, 1'b0);
      check_vec("rst_overrun", overrun, 1'b0);
      check_vec("rst_short", short_line, 1'b0);
      check_vec("rst_shift_count", shift_count, 7'd0);
      check_vec("rst_col", px_col, 6'd0);
      check_vec("rst_data", px_data, 6'd0);
      check_vec("rst_oe_cycles", oe_cycles, 16'd0);

      // Full line, always ready
      ready_mode = 1;
      clear_mon();
      for (int k = 0; k < 64; k++) bus_px(6'(k));
      bus_latch(5'd3);
      wait_done("full");
      for (int c = 0; c < 64; c++) exp_d[c] = 6'(63 - c);
      check_line("full");
      check_vec("full_row", px_row, 5'd3);
      check_vec("full_shift_count", shift_count, 7'd64);
      check_vec("full_short", short_line, 1'b0);
      check_vec("full_overrun", overrun, 1'b0);
      check_vec("full_oe_cycles", oe_cycles, 16'd0);

      // Same line, ready toggling
      ready_mode = 2;
      clear_mon();
      for (int k = 0; k < 64; k++) bus_px(6'(k));
      bus_latch(5'd9);
      wait_done("toggle");
      check_line("toggle");
      check_vec("toggle_row", px_row, 5'd9);
      check_vec("toggle_stalls_seen", 32'(n_stall > 0), 1);
      check_vec("toggle_stall_stable", stall_viol, 0);

      // Short line of 40 pixels
      ready_mode = 1;
      clear_mon();
      for (int k = 0; k < 40; k++) bus_px(6'((k * 3) & 63));
      bus_latch(5'd12);
      wait_done("short");
      for (int c = 0; c < 64; c++) exp_d[c] = (c < 40) ? 6'(((39 - c) * 3) & 63) : 6'(103 - c);
      check_line("short");
      check_vec("short_shift_count", shift_count, 7'd40);
      check_vec("short_flag", short_line, 1'b1);

      // Overrun: second latch during a stalled drain
      ready_mode = 0;
      clear_mon();
      for (int k = 0; k < 64; k++) bus_px(6'((k + 5) & 63));
      bus_latch(5'd17);
      for (int k = 0; k < 10; k++) bus_px(6'h3F);
      bus_latch(5'd30);
      check_vec("ovr_flag", overrun, 1'b1);
      check_vec("ovr_valid", px_valid, 1'b1);
      check_vec("ovr_row", px_row, 5'd17);
      check_vec("ovr_shift_count", shift_count, 7'd64);
      check_vec("ovr_col", px_col, 6'd0);
      ready_mode = 1;
      wait_done("ovr");
      for (int c = 0; c < 64; c++) exp_d[c] = 6'((68 - c) & 63);
      check_line("ovr");
      check_vec("ovr_row_after", px_row, 5'd17);
      check_vec("ovr_stall_stable", stall_viol, 0);

      // Reset mid-drain at col 20
      clear_mon();
      for (int k = 0; k < 64; k++) bus_px(6'(k));
      bus_latch(5'd5);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (px_valid && px_col == 6'd20) found = 1'b1;
         else @(negedge clk);
      end
      check_vec("mid_reached_col20", 32'(found), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_vec("mid_valid", px_valid, 1'b0);
      check_vec("mid_overrun", overrun, 1'b0);
      check_vec("mid_short", short_line, 1'b0);
      check_vec("mid_shift_count", shift_count, 7'd0);
      check_vec("mid_row", px_row, 5'd0);
      repeat (10) @(negedge clk);
      check_vec("mid_no_line_done", ld_cnt, 0);

      // Normal line after the reset
      clear_mon();
      for (int k = 0; k < 64; k++) bus_px(6'(k) ^ 6'h15);
      bus_latch(5'd31);
      wait_done("post");
      for (int c = 0; c < 64; c++) exp_d[c] = 6'(63 - c) ^ 6'h15;
      check_line("post");
      check_vec("post_row", px_row, 5'd31);
      check_vec("post_shift_count", shift_count, 7'd64);
      check_vec("post_short", short_line, 1'b0);
      check_vec("post_overrun", overrun, 1'b0);

      // OE held low for 500 clk between latches
      h75_oe = 1'b0;
      repeat (500) @(negedge clk);
      h75_oe = 1'b1;
      repeat (5) @(negedge clk);
      clear_mon();
      bus_latch(5'd1);
      wait_done("oe");
`ifdef HUB75_CAPTURE_OE_MEASURE_EN
      oe_exp = 32'd500;
`else
      oe_exp = 32'd0;
`endif
      check_vec("oe_cycles", oe_cycles, oe_exp);
      check_vec("oe_shift_count", shift_count, 7'd0);
      check_vec("oe_short", short_line, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
